// File: rtl/lfsr8_checker.sv
// ----------------------------------------------------------------------------
// lfsr8_checker
//
// Purpose:
//   Serial PRBS receiver/checker for the 8-bit Fibonacci LFSR stream
//   x^8+x^6+x^5+x^4+1 (b = S[7]^S[5]^S[4]^S[3], S <= {S[6:0], b}).
//   In HUNT it shifts received bits into a local state. After 8 accepted
//   bits it either locks, or keeps hunting if the captured state is the
//   all-zero lock-up value. In LOCK it free-runs its own LFSR and compares
//   each received bit against the prediction. Too many consecutive
//   mismatches drop it back to HUNT.
//
// Parameters:
//   ERR_LIMIT  consecutive mismatches in LOCK that force a return to HUNT
//              (1..15)
//   CW         width of the saturating error counter
//
// Ports:
//   CLK        system clock, all state changes on the rising edge
//   RESET      asynchronous active-high reset
//   CE         bit-valid strobe; I is only sampled when CE=1
//   I          received serial bit
//   CLR_ERR    synchronous clear of ERR_COUNT (independent of CE)
//   LOCKED     1 while in LOCK
//   ERR        one-cycle pulse per mismatched bit while locked
//   ERR_COUNT  saturating count of mismatched bits
//   O          current local LFSR state
// ----------------------------------------------------------------------------
module lfsr8_checker #(
    parameter int ERR_LIMIT = 4,
    parameter int CW        = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          CE,
    input  logic          I,
    input  logic          CLR_ERR,
    output logic          LOCKED,
    output logic          ERR,
    output logic [CW-1:0] ERR_COUNT,
    output logic [7:0]    O
);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam logic [3:0]    EC_LIMIT = 4'(ERR_LIMIT);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_lfsr;
    logic [7:0]    w_lfsr_next;
    logic [3:0]    r_fc;
    logic [3:0]    w_fc_next;
    logic [3:0]    r_ec;
    logic [3:0]    w_ec_next;
    logic          r_err;
    logic          w_err_next;
    logic [CW-1:0] r_err_count;
    logic [CW-1:0] w_err_count_next;

    logic          w_expected;
    logic [7:0]    w_fill;
    logic [3:0]    w_ec_inc;

    // Prediction of the next transmitted bit from the local state.
    assign w_expected = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_fill     = {r_lfsr[6:0], I};
    assign w_ec_inc   = r_ec + 4'd1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_HUNT;
            r_lfsr      <= 8'h00;
            r_fc        <= 4'd0;
            r_ec        <= 4'd0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_lfsr      <= w_lfsr_next;
            r_fc        <= w_fc_next;
            r_ec        <= w_ec_next;
            r_err       <= w_err_next;
            r_err_count <= w_err_count_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_lfsr_next      = r_lfsr;
        w_fc_next        = r_fc;
        w_ec_next        = r_ec;
        w_err_next       = 1'b0;
        w_err_count_next = r_err_count;

        if (CE) begin
            case (r_state)
                ST_HUNT: begin
                    w_lfsr_next = w_fill;
                    w_fc_next   = r_fc + 4'd1;
                    if (r_fc == 4'd7) begin
                        w_fc_next = 4'd0;
                        // An all-zero capture would free-run as zeros forever,
                        // so it is discarded and the refill starts over.
                        if (w_fill != 8'h00) begin
                            w_state_next = ST_LOCK;
                            w_ec_next    = 4'd0;
                        end
                    end
                end
                ST_LOCK: begin
                    // Flywheel: the local LFSR advances on its own prediction,
                    // so a corrupted received bit never corrupts the state.
                    w_lfsr_next = {r_lfsr[6:0], w_expected};
                    if (I != w_expected) begin
                        w_err_next = 1'b1;
                        if (w_ec_inc == EC_LIMIT) begin
                            w_state_next = ST_HUNT;
                            w_fc_next    = 4'd0;
                            w_ec_next    = 4'd0;
                        end else begin
                            w_ec_next = w_ec_inc;
                        end
                    end else begin
                        w_ec_next = 4'd0;
                    end
                end
                default: begin
                    w_state_next = ST_HUNT;
                end
            endcase
        end

        // Clear wins over a coincident error.
        if (CLR_ERR) begin
            w_err_count_next = '0;
        end else if (w_err_next && (r_err_count != CNT_MAX)) begin
            w_err_count_next = r_err_count + 1'b1;
        end
    end

    assign LOCKED    = (r_state == ST_LOCK);
    assign ERR       = r_err;
    assign ERR_COUNT = r_err_count;
    assign O         = r_lfsr;

endmodule
